// File: rtl/imem_pipelined.sv
// Word-organised instruction memory with a clear-on-reset sweep, loader write port,
// and a LAT-stage valid/ready fetch pipeline that reports alignment and range faults.
module imem_pipelined #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic [31:0] rsp_pc,
    output logic [1:0]  rsp_fault,
    input  logic        flush,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  fault;
        logic [31:0] inst;
    } stage_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            clr_we;

    logic [31:0]     mem [DEPTH];

    stage_t          st_q [LAT];
    logic [LAT-1:0]  sv_q;

    logic            stall;
    logic            accept;
    logic            mis_c;
    logic            oor_c;
    logic [31:0]     rd_word;
    logic            ld_we;
    logic            unused_ld_low;

    // Sweep state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep next-state: one zero write per cycle, then RUN until the next reset
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    assign busy      = (state_q == S_CLEAR);
    assign ld_ready  = (state_q == S_RUN);
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = (state_q == S_RUN) && !flush && !stall;
    assign accept    = req_valid && req_ready;

    assign mis_c   = |req_pc[1:0];
    assign oor_c   = |req_pc[31:AW+2];
    assign rd_word = (mis_c || oor_c) ? 32'd0 : mem[req_pc[AW+1:2]];

    assign ld_we         = ld_valid && ld_ready && !(|ld_addr[31:AW+2]);
    assign unused_ld_low = ^ld_addr[1:0];

    // Storage: the read above samples pre-write contents at the same edge
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q] <= '0;
        end else if (ld_we) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
    end

    // Fetch pipeline; every stage advances together unless the response is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                st_q[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_pc    <= '0;
            rsp_inst  <= '0;
            rsp_fault <= '0;
        end else if (flush) begin
            sv_q      <= '0;
            rsp_valid <= 1'b0;
        end else if (!stall) begin
            sv_q[0] <= accept;
            st_q[0] <= '{pc: req_pc, fault: {oor_c, mis_c}, inst: rd_word};
            for (int i = 1; i < int'(LAT); i++) begin
                sv_q[i] <= sv_q[i-1];
                st_q[i] <= st_q[i-1];
            end
            rsp_valid <= sv_q[LAT-1];
            rsp_pc    <= st_q[LAT-1].pc;
            rsp_fault <= st_q[LAT-1].fault;
            rsp_inst  <= st_q[LAT-1].inst;
        end
    end

endmodule

// File: tb/tb_imem_pipelined.sv
// Randomised and directed bench for imem_pipelined against a queue-based reference
// model that tracks memory contents, in-flight fetches and their ages.
module tb_imem_pipelined;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic        flush;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        busy;

    imem_pipelined #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  fault;
        logic [31:0] inst;
        int          age;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_mem [DEPTH];
    int          cyc;
    int          n_vec;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic mdl_rsp_valid();
        return (q.size() > 0) && (q[0].age == int'(LAT));
    endfunction

    // One clock: drive inputs, check handshakes, advance model, check response
    task automatic step(input logic rv, input logic [31:0] pc, input logic rr,
                        input logic fl, input logic lv, input logic [31:0] la,
                        input logic [31:0] ldd, output logic acc);
        logic run, ev, stl, rdy;
        exp_t e;
        req_valid = rv; req_pc = pc; rsp_ready = rr; flush = fl;
        ld_valid = lv; ld_addr = la; ld_data = ldd;
        run = (cyc >= int'(DEPTH));
        ev  = mdl_rsp_valid();
        stl = ev && !rr;
        rdy = run && !fl && !stl;
        acc = rv && rdy;
        #1;
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("ld_ready", 32'(ld_ready), 32'(run));
        check("busy", 32'(busy), 32'(!run));
        e.pc    = pc;
        e.fault = {pc >= 32'(4 * DEPTH), pc[1:0] != 2'b00};
        e.inst  = (e.fault != 2'b00) ? 32'd0 : mdl_mem[int'((pc >> 2) & 32'(DEPTH - 1))];
        e.age   = 0;
        @(posedge clk);
        cyc++;
        if (fl) begin
            q.delete();
        end else if (!stl) begin
            if (ev) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (acc) q.push_back(e);
        end
        if (lv && run && la < 32'(4 * DEPTH)) begin
            mdl_mem[int'(la >> 2)] = ldd;
        end
        @(negedge clk);
        ev = mdl_rsp_valid();
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            check("rsp_pc", rsp_pc, q[0].pc);
            check("rsp_fault", 32'(rsp_fault), 32'(q[0].fault));
            check("rsp_inst", rsp_inst, q[0].inst);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    endtask

    task automatic fetch(input logic [31:0] pc);
        logic acc;
        step(1'b1, pc, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, acc);
        check("fetch_accept", 32'(acc), 32'd1);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        logic acc;
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, a, d, acc);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0; flush = 1'b0; ld_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_inst", rsp_inst, 32'd0);
        check("rst_rsp_pc", rsp_pc, 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        q.delete();
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = 32'd0;
    endtask

    function automatic logic [31:0] rand_pc();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return $urandom;
        if (r == 1) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
        if (r == 2) return 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    initial begin
        logic acc;
        int   sent;
        n_vec = 0; n_err = 0; cyc = 0;
        req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1; flush = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        do_reset();

        // Sweep length, then fetch of a cleared word
        idle(int'(DEPTH));
        fetch(32'h10);
        idle(int'(LAT) + 1);

        // Load two words and fetch them back-to-back
        load(32'h0, 32'h1F400293);
        load(32'h4, 32'h00440413);
        fetch(32'h0);
        fetch(32'h4);
        idle(int'(LAT) + 2);

        // Fault encodings
        fetch(32'h2);
        fetch(32'h400);
        fetch(32'h403);
        idle(int'(LAT) + 2);

        // Back-pressure mid-stream
        for (int i = 2; i < 8; i++) load(32'(i * 4), $urandom);
        sent = 0;
        for (int t = 0; t < 14; t++) begin
            step(sent < 6, 32'((2 + sent) * 4), !(t >= 5 && t < 8), 1'b0,
                 1'b0, 32'd0, 32'd0, acc);
            if (acc) sent++;
        end
        check("bp_sent", 32'(sent), 32'd6);
        idle(int'(LAT) + 2);

        // Flush with fetches in flight, then flush during a stall
        fetch(32'h8);
        fetch(32'hC);
        step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, acc);
        idle(int'(LAT) + 2);
        fetch(32'h8);
        idle(int'(LAT) - 1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, acc);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, acc);
        idle(int'(LAT) + 2);

        // Reset in the middle of the sweep and in RUN; contents read back as zero
        do_reset();
        idle(100);
        do_reset();
        idle(int'(DEPTH));
        fetch(32'h0);
        fetch(32'h4);
        idle(int'(LAT) + 1);
        load(32'h20, 32'hDEADBEEF);
        fetch(32'h20);
        fetch(32'h24);
        do_reset();
        idle(int'(DEPTH));
        fetch(32'h20);
        idle(int'(LAT) + 1);

        // Random traffic, with one reset in the middle
        for (int t = 0; t < 1500; t++) begin
            if (t == 700) do_reset();
            step($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3,
                 ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 255))
                                              : 32'($urandom_range(0, 127)),
                 $urandom, acc);
        end
        idle(int'(LAT) + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
